// File: rtl/receiver_if.sv
// Link and read-port bundle for the 16-bit Request/Ack receiver.
// The master modport is the sender plus local consumer side; the slave
// modport is the receiver itself.
interface receiver_if;
  logic        Request;
  logic [15:0] DataIn;
  logic        Ack;
  logic        Read;
  logic        DataValid;
  logic [15:0] DataOut;
  logic        Full;
  logic [4:0]  Count;
  logic        BurstDone;
  logic [15:0] Checksum;

  modport master (
    output Request, DataIn, Read,
    input  Ack, DataValid, DataOut, Full, Count, BurstDone, Checksum
  );

  modport slave (
    input  Request, DataIn, Read,
    output Ack, DataValid, DataOut, Full, Count, BurstDone, Checksum
  );
endinterface

// File: rtl/receiver.sv
// Receiver for the 16-bit four-phase Request/Ack link.
// Captured words go into a 16-entry FIFO presented show-ahead to the
// local consumer; captures are grouped into 16-word bursts.
// Optional feature macro: RECEIVER_CHECKSUM_EN builds a per-burst XOR
// checksum; without it Checksum is tied to zero.
//
// state    | meaning
// ---------+-------------------------------------------------------
// WAIT_REQ | Ack low; capture on Request when the FIFO has room
// ACK      | Ack high; word captured, waiting for Request to drop
module receiver #(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 16
) (
  input logic      clk,
  input logic      Reset,
  receiver_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  typedef enum logic {
    WAIT_REQ = 1'b0,
    ACK      = 1'b1
  } link_state_t;

  link_state_t state;
  link_state_t next_state;
  logic        capture;
  logic        pop;
  logic        full;
  logic        not_empty;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [BW-1:0] burst_cnt;
  logic          burst_last;
  logic          burst_done;

  // Full is taken from the registered count, so a pop on the same edge
  // cannot make room for a capture until the following edge.
  assign full       = (count == CNT_FULL);
  assign not_empty  = (count != '0);
  assign pop        = bus.Read && not_empty;
  assign burst_last = (burst_cnt == BURST_LAST);

  // Link FSM state register; reset drops Ack without waiting for a clock.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= WAIT_REQ;
    else       state <= next_state;
  end

  // Link FSM next state and capture strobe: one capture per Request assertion.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      WAIT_REQ: begin
        if (bus.Request && !full) begin
          capture    = 1'b1;
          next_state = ACK;
        end
      end
      ACK: begin
        if (!bus.Request) next_state = WAIT_REQ;
      end
      default: next_state = WAIT_REQ;
    endcase
  end

  // FIFO storage; contents are not reset, the pointers make them stale.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= bus.DataIn;
  end

  // Write and read pointers, wrapping silently at DEPTH.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: a capture and a pop on the same edge cancel out.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else begin
      case ({capture, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Burst position and the one-cycle completion pulse after the last word.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      burst_cnt  <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= capture && burst_last;
      if (capture) burst_cnt <= burst_cnt + BURST_ONE;
    end
  end

`ifdef RECEIVER_CHECKSUM_EN
  logic [15:0] xor_acc;
  logic [15:0] checksum;

  // Running XOR of the current burst; the last word folds straight into
  // the published value so Checksum updates together with BurstDone.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      xor_acc  <= '0;
      checksum <= '0;
    end else if (capture) begin
      if (burst_last) begin
        checksum <= xor_acc ^ bus.DataIn;
        xor_acc  <= '0;
      end else begin
        xor_acc  <= xor_acc ^ bus.DataIn;
      end
    end
  end

  assign bus.Checksum = checksum;
`else
  assign bus.Checksum = 16'h0000;
`endif

  assign bus.Ack       = (state == ACK);
  assign bus.DataValid = not_empty;
  assign bus.DataOut   = mem[rd_ptr];
  assign bus.Full      = full;
  assign bus.Count     = count;
  assign bus.BurstDone = burst_done;

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: a queue-based model of the link/FIFO/burst rules,
// a per-cycle compare against it, and directed scenarios with literal
// expectations.
module tb_receiver;

  logic clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  receiver_if bus_if ();

  receiver u_dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  int n_run  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // reference model state
  logic [15:0] m_q[$];
  logic [15:0] m_burst[$];
  logic        m_ack  = 1'b0;
  logic        m_done = 1'b0;
  logic [15:0] m_cs   = 16'h0000;
  logic        m_cap;
  logic        m_pop;
  logic [15:0] m_x;

  // stimulus-side bookkeeping
  int          bd_cnt  = 0;
  int          max_cnt = 0;
  logic [15:0] pop_log[$];

  // model: evaluates the link and FIFO rules at each clock edge
  always @(posedge clk or posedge Reset) begin
    if (Reset) begin
      m_q.delete();
      m_burst.delete();
      m_ack  = 1'b0;
      m_done = 1'b0;
      m_cs   = 16'h0000;
    end else begin
      m_cap  = !m_ack && bus_if.Request && (m_q.size() < 16);
      m_pop  = bus_if.Read && (m_q.size() != 0);
      m_done = 1'b0;
      if (m_pop) void'(m_q.pop_front());
      if (m_cap) begin
        m_q.push_back(bus_if.DataIn);
        m_burst.push_back(bus_if.DataIn);
        if (m_burst.size() == 16) begin
          m_done = 1'b1;
          m_x = 16'h0000;
          for (int i = 0; i < 16; i++) m_x = m_x ^ m_burst[i];
`ifdef RECEIVER_CHECKSUM_EN
          m_cs = m_x;
`else
          m_cs = 16'h0000;
`endif
          m_burst.delete();
        end
      end
      m_ack = m_ack ? bus_if.Request : m_cap;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    if (bus_if.Read && bus_if.DataValid) pop_log.push_back(bus_if.DataOut);
    @(posedge clk);
    #2;
    if (bus_if.BurstDone) bd_cnt++;
    if (int'(bus_if.Count) > max_cnt) max_cnt = int'(bus_if.Count);
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (bus_if.Ack !== v && n < 20) begin
      tick();
      n++;
    end
    if (bus_if.Ack !== v) check("ack_timeout", 32'(bus_if.Ack), 32'(v));
  endtask

  task automatic handshake(input logic [15:0] w);
    bus_if.Request = 1'b1;
    bus_if.DataIn  = w;
    tick();
    wait_ack(1'b1);
    bus_if.Request = 1'b0;
    tick();
    wait_ack(1'b0);
  endtask

  task automatic do_reset();
    bus_if.Request = 1'b0;
    bus_if.Read    = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.Request = 1'b0;
    bus_if.DataIn  = 16'h0000;
    bus_if.Read    = 1'b0;

    // per-cycle compare against the model
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check("cyc_ack",        32'(bus_if.Ack),       32'(m_ack));
          check("cyc_count",      32'(bus_if.Count),     32'(m_q.size()));
          check("cyc_valid",      32'(bus_if.DataValid), 32'(m_q.size() != 0));
          check("cyc_full",       32'(bus_if.Full),      32'(m_q.size() == 16));
          check("cyc_burst_done", 32'(bus_if.BurstDone), 32'(m_done));
          check("cyc_checksum",   32'(bus_if.Checksum),  32'(m_cs));
          if (m_q.size() != 0) check("cyc_data_out", 32'(bus_if.DataOut), 32'(m_q[0]));
        end
      end
    join_none

    // reset state
    do_reset();
    chk_en = 1'b1;
    check("rst_ack",       32'(bus_if.Ack),       32'h0);
    check("rst_count",     32'(bus_if.Count),     32'h0);
    check("rst_valid",     32'(bus_if.DataValid), 32'h0);
    check("rst_full",      32'(bus_if.Full),      32'h0);
    check("rst_bdone",     32'(bus_if.BurstDone), 32'h0);
    check("rst_checksum",  32'(bus_if.Checksum),  32'h0);

    // single word
    bus_if.Request = 1'b1;
    bus_if.DataIn  = 16'hA5A5;
    tick();
    check("single_ack",   32'(bus_if.Ack),     32'h1);
    check("single_count", 32'(bus_if.Count),   32'h1);
    check("single_data",  32'(bus_if.DataOut), 32'hA5A5);
    bus_if.Request = 1'b0;
    tick();
    check("single_ack_drop", 32'(bus_if.Ack), 32'h0);

    // full burst of 0x0001..0x0010, no reads
    do_reset();
    bd_cnt = 0;
    for (int i = 1; i <= 16; i++) handshake(16'(i));
    check("burst_full",  32'(bus_if.Full),  32'h1);
    check("burst_count", 32'(bus_if.Count), 32'd16);
    check("burst_pulses", 32'(bd_cnt), 32'd1);
`ifdef RECEIVER_CHECKSUM_EN
    check("burst_checksum", 32'(bus_if.Checksum), 32'h0010);
`else
    check("burst_checksum", 32'(bus_if.Checksum), 32'h0000);
`endif

    // back-pressure while full
    bus_if.Request = 1'b1;
    bus_if.DataIn  = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ack_held", 32'(bus_if.Ack),   32'h0);
      check("bp_count",    32'(bus_if.Count), 32'd16);
    end
    check("bp_head", 32'(bus_if.DataOut), 32'h0001);
    bus_if.Read = 1'b1;
    tick();
    bus_if.Read = 1'b0;
    check("bp_pop_count", 32'(bus_if.Count),   32'd15);
    check("bp_pop_head",  32'(bus_if.DataOut), 32'h0002);
    check("bp_pop_ack",   32'(bus_if.Ack),     32'h0);
    tick();
    check("bp_cap_ack",   32'(bus_if.Ack),   32'h1);
    check("bp_cap_count", 32'(bus_if.Count), 32'd16);
    bus_if.Request = 1'b0;
    tick();
    wait_ack(1'b0);

    // simultaneous capture and pop at Count=5
    do_reset();
    for (int i = 0; i < 5; i++) handshake(16'h0100 + 16'(i));
    check("sim_pre_count", 32'(bus_if.Count),   32'd5);
    check("sim_pre_head",  32'(bus_if.DataOut), 32'h0100);
    bus_if.Request = 1'b1;
    bus_if.DataIn  = 16'h0105;
    bus_if.Read    = 1'b1;
    tick();
    bus_if.Read = 1'b0;
    check("sim_count", 32'(bus_if.Count),   32'd5);
    check("sim_head",  32'(bus_if.DataOut), 32'h0101);
    check("sim_ack",   32'(bus_if.Ack),     32'h1);
    bus_if.Request = 1'b0;
    tick();
    wait_ack(1'b0);

    // 40 words streamed with Read held high, across pointer wrap
    do_reset();
    bd_cnt  = 0;
    max_cnt = 0;
    pop_log.delete();
    bus_if.Read = 1'b1;
    for (int i = 0; i < 40; i++) handshake(16'h1000 + 16'(i));
    tick();
    tick();
    bus_if.Read = 1'b0;
    check("wrap_pulses",   32'(bd_cnt), 32'd2);
    check("wrap_max_le2",  32'(max_cnt <= 2), 32'h1);
    check("wrap_drained",  32'(bus_if.Count), 32'd0);
    check("wrap_pop_total", 32'(pop_log.size()), 32'd40);
    for (int i = 0; i < 40 && i < pop_log.size(); i++)
      check("wrap_order", 32'(pop_log[i]), 32'h1000 + 32'(i));

    // reset in the middle of a handshake
    do_reset();
    handshake(16'h0201);
    handshake(16'h0202);
    bus_if.Request = 1'b1;
    bus_if.DataIn  = 16'h0203;
    tick();
    check("mid_pre_ack",   32'(bus_if.Ack),   32'h1);
    check("mid_pre_count", 32'(bus_if.Count), 32'd3);
    Reset = 1'b1;
    #1;
    check("mid_rst_ack",   32'(bus_if.Ack),       32'h0);
    check("mid_rst_count", 32'(bus_if.Count),     32'h0);
    check("mid_rst_valid", 32'(bus_if.DataValid), 32'h0);
    tick();
    Reset  = 1'b0;
    bd_cnt = 0;
    tick();
    check("mid_recap_count", 32'(bus_if.Count),   32'd1);
    check("mid_recap_ack",   32'(bus_if.Ack),     32'h1);
    check("mid_recap_data",  32'(bus_if.DataOut), 32'h0203);
    bus_if.Request = 1'b0;
    tick();
    wait_ack(1'b0);
    for (int i = 0; i < 14; i++) handshake(16'h0300 + 16'(i));
    check("mid_no_pulse_yet", 32'(bd_cnt), 32'd0);
    handshake(16'h030E);
    check("mid_burst_pulse", 32'(bd_cnt), 32'd1);
    check("mid_full",        32'(bus_if.Full), 32'h1);

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/receiver.md
# receiver

Downstream consumer of the 16-bit Request/Ack sender link. Accepts words over a four-phase Request/Ack handshake and stores them in a 16-entry FIFO. Presents them on a show-ahead read port to the local consumer. Counts words into 16-word bursts and flags each completed burst; back-pressures the sender by withholding Ack while the FIFO is full.

## Interface
- DEPTH, 16, FIFO entries; power of two; fixed at 16 for this link.
- BURST_LEN, 16, words per burst; matches the sender's 16-word sequence.

Ports:
- clk  in  1  clock, all state on rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- Request  in  1  sender holds high with DataIn stable until Ack seen.
- DataIn  in  16  word from sender.
- Ack  out  1  registered handshake acknowledge.
- Read  in  1  consumer pop strobe.
- DataValid  out  1  FIFO non-empty.
- DataOut  out  16  FIFO head word (show-ahead).
- Full  out  1  FIFO holds DEPTH words.
- Count  out  5  FIFO occupancy, 0..16.
- BurstDone  out  1  one-cycle pulse after BURST_LEN-th word of a burst is captured.
- Checksum  out  16  XOR of last completed burst; see Configuration.

## Operation
- Link FSM, 2 states:
  - WAIT_REQ: Ack=0. If Request=1 and Full=0, write DataIn at wr_ptr, advance wr_ptr, go to ACK. If Request=1 and Full=1, stay; no capture.
  - ACK: Ack=1. Stay while Request=1. On Request=0, go to WAIT_REQ.
- Each Request assertion produces exactly one capture.
- Burst counter: 4-bit, increments per capture, wraps 15->0. BurstDone=1 in the cycle after the capture that wraps it.
- Read side: DataOut = mem[rd_ptr]. Read=1 with DataValid=1 pops: rd_ptr+1, mod 16. Read with DataValid=0 is ignored.
- Count: +1 on capture only, -1 on pop only, unchanged on simultaneous capture and pop.
- Full=(Count==16); DataValid=(Count!=0). Pointers are 4-bit and wrap silently.
- Capture while full is impossible; the FSM holds in WAIT_REQ, Ack stays 0, and the sender stalls in its REQUEST state.
- Capture while full with a pop in the same cycle is not allowed: Full is evaluated before the pop.

## Timing
- Reset values: Ack=0, DataValid=0, DataOut=mem[0] (don't-care), Full=0, Count=0, BurstDone=0, Checksum=0. FSM=WAIT_REQ, pointers=0, burst counter=0.
- Capture edge N (Request high, not full) -> Ack=1, Count+1, DataValid=1 after edge N.
- Ack drops the cycle after the edge where Request is sampled low. Minimum handshake is 3 cycles against the sender's REQUEST -> ACKNOWLEDGE path.
- A pop takes effect at the edge; the new head is visible on DataOut after that edge. Read-to-data latency is 0 (show-ahead).
- Reset mid-handshake: Ack drops asynchronously. FIFO contents are discarded and the burst count restarts at 0. A sender still holding Request is recaptured as word 0 after Reset deasserts.

## Configuration
- RECEIVER_CHECKSUM_EN defined:
  - 16-bit running XOR of captured words; it clears at Reset and at each burst boundary.
  - On the cycle BurstDone pulses, Checksum loads the final XOR (including the 16th word) and holds until the next BurstDone.
- RECEIVER_CHECKSUM_EN undefined: no accumulator is built and Checksum is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Single word: Reset, Request=1 with DataIn=16'hA5A5 -> Ack=1 next cycle, Count=1, DataOut=16'hA5A5. Drop Request -> Ack=0 one cycle later.
- Full burst: 16 handshakes with words 0x0001..0x0010, no reads -> Full=1, Count=16, BurstDone pulses once after the 16th capture. Checksum=16'h0010 with RECEIVER_CHECKSUM_EN, 0 without.
- Back-pressure: with FIFO full, hold Request=1 -> Ack stays 0. Pulse Read once -> word 0x0001 popped, next-cycle capture occurs, Ack=1, Count stays 16.
- Simultaneous: Count=5, capture and Read on the same edge -> Count=5 and the head advances by one.
- Wrap: 40 words streamed with Read continuously high -> data order preserved across pointer wrap, BurstDone pulses at words 16 and 32, Count never exceeds 2.
- Reset mid-handshake: assert Reset while Ack=1 and Count=3 -> Ack, Count and DataValid go to 0 immediately. After release with Request still high -> one new capture, burst count 1.
